// File: rtl/skid_slice.sv
// Two-entry valid/ready register slice with skid buffer.
// Outputs depend only on registered state, so no input-to-output path exists.
module skid_slice #(
    parameter int unsigned     DW      = 32,
    parameter logic [DW-1:0]   DEFAULT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          s_valid_i,
    input  logic [DW-1:0] s_data_i,
    output logic          s_ready_o,
    output logic          m_valid_o,
    output logic [DW-1:0] m_data_o,
    input  logic          m_ready_i,
    output logic [1:0]    level_o
);

    // Encoding equals the number of words held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          s_fire;
    logic          m_fire;
    logic          ld_main_in;
    logic          ld_main_skid;
    logic          ld_skid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and data-path load enables
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        s_fire       = s_valid_i & s_ready_o;
        m_fire       = m_valid_o & m_ready_i;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (s_fire) begin
                        ld_main_in = 1'b1;
                        state_d    = BUSY;
                    end
                end
                BUSY: begin
                    if (s_fire && m_fire) begin
                        ld_main_in = 1'b1;
                    end else if (s_fire) begin
                        ld_skid = 1'b1;
                        state_d = FULL;
                    end else if (m_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (m_fire) begin
                        ld_main_skid = 1'b1;
                        state_d      = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        m_valid_o = 1'b0;
        s_ready_o = 1'b1;
        level_o   = 2'd0;
        case (state_q)
            BUSY: begin
                m_valid_o = 1'b1;
                level_o   = 2'd1;
            end
            FULL: begin
                m_valid_o = 1'b1;
                s_ready_o = 1'b0;
                level_o   = 2'd2;
            end
            default: begin
                m_valid_o = 1'b0;
                s_ready_o = 1'b1;
                level_o   = 2'd0;
            end
        endcase
    end

    // Data registers; flush restores the reset contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= DEFAULT;
            skid_q <= DEFAULT;
        end else if (flush_i) begin
            main_q <= DEFAULT;
            skid_q <= DEFAULT;
        end else begin
            if (ld_main_in) begin
                main_q <= s_data_i;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= s_data_i;
            end
        end
    end

    assign m_data_o = main_q;

endmodule
